// File: rtl/pipo_pkg.sv
// Shared types and defaults for the two-requester holding-register arbiter.
package pipo_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef logic req_idx_t;

   // The requester that should be favoured after idx has been served.
   function automatic req_idx_t next_prio(input req_idx_t idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/pipo_arb_chk.sv
// Protocol checks on the arbiter's grant output.
module pipo_arb_chk (
   input logic       clk,
   input logic       reset,
   input logic       clear,
   input logic [1:0] req_ready
);

   a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(req_ready));

   a_clear_blocks: assert property (@(posedge clk) disable iff (reset)
      clear |-> (req_ready == 2'b00));

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: one-hot grant plus winner index, purely combinational.
module rr_arb2
   import pipo_pkg::*;
(
   input  logic [1:0] req,
   input  req_idx_t   prio,
   input  logic       enable,
   output logic [1:0] gnt,
   output req_idx_t   idx
);

   logic [1:0] gnt_s;
   req_idx_t   idx_s;

   // Winner selection; prio only matters when both requesters are valid.
   always_comb begin
      gnt_s = 2'b00;
      idx_s = 1'b0;
      if (enable) begin
         case (req)
            2'b01: begin
               gnt_s = 2'b01;
               idx_s = 1'b0;
            end
            2'b10: begin
               gnt_s = 2'b10;
               idx_s = 1'b1;
            end
            2'b11: begin
               if (prio) begin
                  gnt_s = 2'b10;
                  idx_s = 1'b1;
               end else begin
                  gnt_s = 2'b01;
                  idx_s = 1'b0;
               end
            end
            default: begin
               gnt_s = 2'b00;
               idx_s = 1'b0;
            end
         endcase
      end else begin
         gnt_s = 2'b00;
         idx_s = 1'b0;
      end
   end

   assign gnt = gnt_s;
   assign idx = idx_s;

endmodule

// File: rtl/pipo_arb.sv
// Round-robin load controller sharing one parallel holding register between two
// requesters, with a valid/ready consumer side and back-to-back reload.
module pipo_arb
   import pipo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   output logic [1:0]       req_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_src,
   output logic [CNT_W-1:0] xfer_count
);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] out_data_r;
   req_idx_t         out_src_r;
   req_idx_t         prio_r;
   logic [CNT_W-1:0] xfer_count_r;

   logic             out_valid_s;
   logic             free_s;
   logic             grant_en_s;
   logic [1:0]       gnt_s;
   req_idx_t         win_idx_s;
   logic             xfer_s;
   logic [WIDTH-1:0] win_data_s;

   assign out_valid_s = (state_r == FULL);
   assign free_s      = (state_r == EMPTY) | (out_valid_s & out_ready);
   // reset gates the grant so req_ready is low for the whole reset pulse.
   assign grant_en_s  = free_s & ~clear & ~reset;

   rr_arb2 u_rr_arb2 (
      .req    (req_valid),
      .prio   (prio_r),
      .enable (grant_en_s),
      .gnt    (gnt_s),
      .idx    (win_idx_s)
   );

   assign xfer_s     = |(gnt_s & req_valid);
   assign win_data_s = win_idx_s ? req_data1 : req_data0;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: a transfer always fills; otherwise a consume or clear empties.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         EMPTY: begin
            if (xfer_s) begin
               state_nxt_s = FULL;
            end else begin
               state_nxt_s = EMPTY;
            end
         end
         FULL: begin
            if (xfer_s) begin
               state_nxt_s = FULL;
            end else if (out_ready || clear) begin
               state_nxt_s = EMPTY;
            end else begin
               state_nxt_s = FULL;
            end
         end
         default: begin
            state_nxt_s = EMPTY;
         end
      endcase
   end

   // Holding register, source tag and round-robin pointer load on a transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_r <= {WIDTH{1'b0}};
         out_src_r  <= 1'b0;
         prio_r     <= 1'b0;
      end else if (xfer_s) begin
         out_data_r <= win_data_s;
         out_src_r  <= win_idx_s;
         prio_r     <= next_prio(win_idx_s);
      end else begin
         out_data_r <= out_data_r;
         out_src_r  <= out_src_r;
         prio_r     <= prio_r;
      end
   end

   // Accepted-transfer counter; wraps silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xfer_count_r <= {CNT_W{1'b0}};
      end else if (xfer_s) begin
         xfer_count_r <= xfer_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         xfer_count_r <= xfer_count_r;
      end
   end

   assign req_ready  = gnt_s;
   assign out_data   = out_data_r;
   assign out_valid  = out_valid_s;
   assign out_src    = out_src_r;
   assign xfer_count = xfer_count_r;

endmodule
